// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multicycle controller and its datapath.
// The controller takes the master modport; the datapath (or a bench) takes the slave modport.
interface multicycle_ctrl_if;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;

  logic        pc_write;
  logic        pc_write_cond;
  logic        i_or_d;
  logic        mem_req;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic        reg_dst;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic [1:0]  pc_source;

  logic [3:0]  state;
  logic        illegal;
  logic [15:0] retired;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_req, mem_read, mem_write,
           ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b,
           alu_op, pc_source, state, illegal, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_req, mem_read, mem_write,
           ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b,
           alu_op, pc_source, state, illegal, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore-style multicycle MIPS-subset controller with memory-ready stalls.
// Define MCTRL_JUMP_EN to decode opcode 000010 (j); otherwise it is illegal.
module multicycle_ctrl (
  input logic               clk,
  input logic               rst_n,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  REXEC  = 4'd6,  RWB    = 4'd7,
    BEQ    = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11,
    HALT   = 4'd12
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef MCTRL_JUMP_EN
  localparam logic [5:0] OP_J    = 6'b000010;
`endif

  state_e      state_q, state_d;
  logic        illegal_q;
  logic [15:0] retired_q;
  logic        retire;
  logic        fetch_ack;
  logic        zero_unused;

  // The branch decision on zero is made in the datapath, not here.
  assign zero_unused = bus.zero;

  // Reset forces the FETCH decode as if memory had not yet acknowledged.
  assign fetch_ack = bus.mem_ready & rst_n;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      retired_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_d == HALT) illegal_q <= 1'b1;
      if (retire)          retired_q <= retired_q + 16'd1;
    end
  end

  assign retire = (state_d == FETCH) &&
                  (state_q inside {MEMWB, MEMWR, RWB, BEQ, ADDIWB, JUMP});

  // NOTE: next state gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = REXEC;
          OP_BEQ:       state_d = BEQ;
          OP_ADDI:      state_d = ADDIEX;
`ifdef MCTRL_JUMP_EN
          OP_J:         state_d = JUMP;
`endif
          default:      state_d = HALT;
        endcase
      end
      MEMADR: state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = bus.mem_ready ? MEMWB : MEMRD;
      MEMWB:  state_d = FETCH;
      MEMWR:  state_d = bus.mem_ready ? FETCH : MEMWR;
      REXEC:  state_d = RWB;
      RWB:    state_d = FETCH;
      BEQ:    state_d = FETCH;
      ADDIEX: state_d = ADDIWB;
      ADDIWB: state_d = FETCH;
      JUMP:   state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_req       = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 3'b000;
    bus.pc_source     = 2'b00;
    case (state_q)
      FETCH: begin
        bus.mem_req   = 1'b1;
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = fetch_ack;
        bus.pc_write  = fetch_ack;
      end
      DECODE: bus.alu_src_b = 2'b11;
      MEMADR, ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      MEMRD: begin
        bus.mem_req  = 1'b1;
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        bus.mem_req   = 1'b1;
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
      end
      REXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 3'b010;
      end
      RWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      BEQ: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 3'b001;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
      end
      ADDIWB: bus.reg_write = 1'b1;
      JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.state   = state_q;
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 rising-edge clock; rst_n input 1 asynchronous active-low reset.
REQ-002 The block SHALL have these inputs: opcode input 6 IR[31:26]; zero input 1 ALU zero flag; mem_ready input 1 memory done/acknowledge.
REQ-003 The block SHALL have these control outputs, all 1 bit: pc_write; pc_write_cond (branch-qualified PC write); i_or_d (0 = PC addresses memory, 1 = ALUOut); mem_req; mem_read; mem_write; ir_write; mem_to_reg; reg_write; reg_dst; alu_src_a.
REQ-004 The block SHALL have these control outputs: alu_src_b output 2 (00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2); alu_op output 3 (000 add, 001 sub, 010 funct-decode); pc_source output 2 (00 ALU, 01 ALUOut, 10 jump target).
REQ-005 The block SHALL have these status outputs: state output 4 current state; illegal output 1 sticky bad-opcode flag; retired output 16 instruction-completion count.

Function
REQ-006 Decoded opcodes SHALL be: 000000 R-type, 100011 lw, 101011 sw, 000100 beq, 001000 addi, 000010 j (see REQ-021); all others SHALL be illegal.
REQ-007 The FSM SHALL use this state encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11, HALT=12; codes 13-15 SHALL go to FETCH on the next edge.
REQ-008 FETCH SHALL drive mem_req=1, mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00; ir_write and pc_write SHALL be 1 only in the cycle mem_ready=1.
REQ-009 FETCH SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-010 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=000 (branch target), and SHALL go to MEMADR for lw/sw, REXEC for R, BEQ for beq, ADDIEX for addi, JUMP for j, HALT otherwise.
REQ-011 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=000, and SHALL go to MEMRD for lw and MEMWR for sw.
REQ-012 MEMRD SHALL drive mem_req=1, mem_read=1, i_or_d=1, stall while mem_ready=0, and go to MEMWB when mem_ready=1.
REQ-013 MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-014 MEMWR SHALL drive mem_req=1, mem_write=1, i_or_d=1, stall while mem_ready=0, and go to FETCH when mem_ready=1.
REQ-015 REXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=010, then go to RWB; RWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-016 BEQ SHALL drive alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01, then go to FETCH (the datapath qualifies the PC write with zero).
REQ-017 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=000, then go to ADDIWB; ADDIWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-018 HALT SHALL set illegal=1, drive all enables 0, and remain in HALT until reset.
REQ-019 All outputs SHALL be a Moore decode of the registered state, except the ir_write/pc_write gating in REQ-008; any output not listed for a state SHALL be 0.
REQ-020 retired SHALL increment by 1, wrapping 0xFFFF->0x0000, on each transition into FETCH from MEMWB, MEMWR, RWB, BEQ, ADDIWB or JUMP.

Configuration
REQ-021 With macro MCTRL_JUMP_EN defined, opcode 000010 SHALL go DECODE->JUMP, and JUMP SHALL drive pc_write=1, pc_source=10, then go to FETCH; without the macro, 000010 SHALL be illegal (DECODE->HALT) and the JUMP state SHALL be unreachable.

Reset
REQ-022 When rst_n=0, asynchronously: state=FETCH, illegal=0, retired=0.
REQ-023 When rst_n=0, all outputs SHALL equal the FETCH decode with mem_ready treated as 0.
REQ-024 Reset asserted mid-stall (in MEMRD, MEMWR or FETCH) SHALL abort the access, and mem_req SHALL follow the FETCH decode from the reset edge.
REQ-025 After rst_n deasserts, the first state change SHALL occur on the first clk rising edge.

Verification
REQ-026 R-type, mem_ready=1 on the first FETCH cycle: state sequence 0,1,6,7,0; reg_dst=1 and reg_write=1 only in RWB; retired 0->1.
REQ-027 lw with mem_ready held 0 for 3 cycles in MEMRD: state 3 for 4 cycles, then 4 then 0; mem_to_reg=1 in MEMWB.
REQ-028 beq: BEQ state asserts pc_write_cond=1, alu_op=001, pc_source=01 for exactly one cycle.
REQ-029 Opcode 111111: DECODE->HALT; illegal=1 stays high for 20+ cycles; rst_n pulse clears it and returns state to 0.
REQ-030 j with MCTRL_JUMP_EN: state 0,1,11,0, pc_source=10; without the macro: state 0,1,12.
REQ-031 Preload retired=0xFFFF via 65535 addi instructions, then one more: retired wraps to 0x0000.
